// File: rtl/board_pkg.sv
// Shared playfield constants and clear-sequencer state encoding for the board
// store and the display logic.
package board_pkg;

  localparam int COLS     = 36;  // 576 px / 16
  localparam int ROWS     = 18;  // 288 px / 16
  localparam int XW       = 6;
  localparam int YW       = 5;
  localparam int CELL_PX  = 16;
  localparam int BOARD_X0 = 32;
  localparam int BOARD_Y0 = 32;
  localparam int CNT_W    = 10;

  localparam logic [XW-1:0]    COLS_X    = XW'(COLS);
  localparam logic [YW-1:0]    ROWS_Y    = YW'(ROWS);
  localparam logic [YW-1:0]    LAST_ROW  = YW'(ROWS - 1);
  localparam logic [CNT_W-1:0] CELLS_MAX = CNT_W'(COLS * ROWS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic in_board(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x < COLS_X) && (y < ROWS_Y);
  endfunction

endpackage

// File: rtl/board_clr_seq.sv
// Row-sweep clear sequencer: clears one board row per cycle, starting at
// reset and on every clr_req seen while idle.
module board_clr_seq
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          clr_busy_o,
  output logic [YW-1:0] clr_row_o
);

  clr_state_e    state_q, state_d;
  logic [YW-1:0] row_q, row_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (row_q == LAST_ROW) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          row_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        row_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy_o = (state_q == ST_CLEAR);
    clr_row_o  = row_q;
  end

endmodule

// File: rtl/board_mem.sv
// Snake playfield cell bitmap: 1-cycle display read port, valid/ready write
// port with self-collision hit report, row-sweep clear.
// Define BOARD_COUNT_EN to build the set-cell counter on 'occupied'.
module board_mem
  import board_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic             rd_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic             wr_data,
  output logic             wr_hit,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [CNT_W-1:0] occupied
);

  logic [COLS-1:0] cells_q [ROWS];
  logic [YW-1:0]   clr_row;
  logic            wr_fire, wr_in, old_cell;
  logic            rd_data_q, rd_data_d;
  logic            hit_q, hit_d;

  board_clr_seq u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_row_o  (clr_row)
  );

  // A clear request wins over a write presented in the same cycle.
  assign wr_ready = !clr_busy && !clr_req;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_in    = in_board(wr_x, wr_y);
  assign old_cell = wr_in ? cells_q[wr_y][wr_x] : 1'b0;

  // NOTE: the cell array has no reset; the sweep that reset starts is what
  // clears it, which keeps it mappable onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      cells_q[clr_row] <= '0;
    end else if (wr_fire && wr_in) begin
      cells_q[wr_y][wr_x] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = 1'b0;
    if (!clr_busy && in_board(rd_x, rd_y)) rd_data_d = cells_q[rd_y][rd_x];
    hit_d = wr_fire && wr_in && wr_data && old_cell;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      hit_q     <= hit_d;
    end
  end

  assign rd_data = rd_data_q;
  assign wr_hit  = hit_q;

`ifdef BOARD_COUNT_EN
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             sweep_done;

  assign sweep_done = clr_busy && (clr_row == LAST_ROW);

  // Only real 0->1 / 1->0 transitions move the count; the guards make
  // wrap-around impossible even if the array and count ever disagree.
  always_comb begin
    occ_d = occ_q;
    if (sweep_done) begin
      occ_d = '0;
    end else if (wr_fire && wr_in) begin
      if (wr_data && !old_cell && occ_q != CELLS_MAX) occ_d = occ_q + 1'b1;
      else if (!wr_data && old_cell && occ_q != '0)   occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupied = occ_q;
`else
  assign occupied = '0;
`endif

endmodule

// File: tb/tb_board_mem.sv
// Directed bench for board_mem: reset sweep, read/write/hit vector table,
// clear-vs-write priority, sweep timing, optional occupancy counter, reset mid-sweep.
module tb_board_mem;
  import board_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XW-1:0]    rd_x = '0;
  logic [YW-1:0]    rd_y = '0;
  logic             rd_data;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [XW-1:0]    wr_x = '0;
  logic [YW-1:0]    wr_y = '0;
  logic             wr_data = 1'b0;
  logic             wr_hit;
  logic             clr_req = 1'b0;
  logic             clr_busy;
  logic [CNT_W-1:0] occupied;

  int checks = 0;
  int errors = 0;

`ifdef BOARD_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  board_mem dut (
    .clk      (clk),
    .rst      (rst),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_data  (rd_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .wr_hit   (wr_hit),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .occupied (occupied)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic do_write(input int x, input int y, input logic d);
    wr_valid = 1'b1;
    wr_x     = XW'(x);
    wr_y     = YW'(y);
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic          wd;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic          exp_rd;
    logic          exp_hit;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int n;
    int ones;

    //            we  wx  wy  wd  rx  ry  rd hit
    vecs[0]  = '{1'b1, 6'd5,  5'd3,  1'b1, 6'd5,  5'd3,  1'b0, 1'b0}; // same-cell read sees old
    vecs[1]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd5,  5'd3,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd6,  5'd3,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 6'd5,  5'd3,  1'b1, 6'd5,  5'd3,  1'b1, 1'b1}; // self-collision
    vecs[4]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd0,  5'd0,  1'b0, 1'b0}; // hit is one cycle
    vecs[5]  = '{1'b1, 6'd5,  5'd3,  1'b0, 6'd5,  5'd3,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd5,  5'd3,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 6'd40, 5'd3,  1'b1, 6'd36, 5'd0,  1'b0, 1'b0}; // out-of-range write/read
    vecs[8]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd0,  5'd18, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd4,  5'd3,  1'b0, 1'b0}; // no aliasing of x=40
    vecs[10] = '{1'b1, 6'd0,  5'd0,  1'b1, 6'd0,  5'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 6'd35, 5'd17, 1'b1, 6'd0,  5'd0,  1'b1, 1'b0};
    vecs[12] = '{1'b1, 6'd35, 5'd17, 1'b1, 6'd35, 5'd17, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 6'd0,  5'd0,  1'b1, 6'd35, 5'd0,  1'b0, 1'b1};
    vecs[14] = '{1'b1, 6'd0,  5'd17, 1'b1, 6'd0,  5'd17, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 6'd0,  5'd0,  1'b0, 6'd0,  5'd17, 1'b1, 1'b0};

    // Reset state and power-up sweep length.
    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_wr_hit", 32'(wr_hit), 0);
    check("rst_occupied", 32'(occupied), 0);
    check("rst_clr_busy", 32'(clr_busy), 1);
    rst = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      check("init_sweep_busy", 32'(clr_busy), 1);
      check("init_sweep_ready", 32'(wr_ready), 0);
      @(negedge clk);
    end
    check("init_sweep_end_busy", 32'(clr_busy), 0);
    check("init_sweep_end_ready", 32'(wr_ready), 1);
    check("init_rd_00", 32'(rd_data), 0);

    // Table-driven read/write/hit vectors, one cycle each.
    for (int i = 0; i < 16; i++) begin
      wr_valid = vecs[i].we;
      wr_x     = vecs[i].wx;
      wr_y     = vecs[i].wy;
      wr_data  = vecs[i].wd;
      rd_x     = vecs[i].rx;
      rd_y     = vecs[i].ry;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(wr_ready), 1);
      @(negedge clk);
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_wr_hit", i), 32'(wr_hit), 32'(vecs[i].exp_hit));
    end
    wr_valid = 1'b0;

    // Clear beats a same-cycle write onto a set cell; clr_req mid-sweep ignored.
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_x     = 6'd0;
    wr_y     = 5'd0;
    wr_data  = 1'b1;
    rd_x     = 6'd0;
    rd_y     = 5'd0;
    #1;
    check("clr_vs_wr_ready", 32'(wr_ready), 0);
    @(negedge clk);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 1'b0;
    check("clr_vs_wr_hit", 32'(wr_hit), 0);
    for (int k = 0; k < ROWS; k++) begin
      check("clr_sweep_busy", 32'(clr_busy), 1);
      // First sample still reflects the IDLE cycle that accepted clr_req.
      check("clr_sweep_rd", 32'(rd_data), (k == 0) ? 32'd1 : 32'd0);
      clr_req = (k == 7);
      @(negedge clk);
    end
    clr_req = 1'b0;
    check("clr_sweep_end_busy", 32'(clr_busy), 0);

    ones = 0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        rd_x = XW'(x);
        rd_y = YW'(y);
        @(negedge clk);
        if (rd_data !== 1'b0) ones++;
      end
    end
    check("clr_all_cells_zero", 32'(ones), 0);

    // Occupancy counter (tied to 0 when the feature is not built).
    check("occ_after_clear", 32'(occupied), 0);
    do_write(1, 1, 1'b1);
    do_write(2, 2, 1'b1);
    do_write(3, 3, 1'b1);
    check("occ_three_set", 32'(occupied), cnt_exp(3));
    do_write(2, 2, 1'b1);
    check("occ_reset_hit", 32'(wr_hit), 1);
    check("occ_one_to_one", 32'(occupied), cnt_exp(3));
    do_write(1, 1, 1'b0);
    check("occ_one_to_zero", 32'(occupied), cnt_exp(2));
    do_write(40, 3, 1'b1);
    check("occ_oor_hit", 32'(wr_hit), 0);
    check("occ_oor", 32'(occupied), cnt_exp(2));
    do_write(7, 7, 1'b0);
    check("occ_zero_to_zero", 32'(occupied), cnt_exp(2));
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (5) @(negedge clk);
    check("occ_mid_sweep_busy", 32'(clr_busy), 1);
    check("occ_mid_sweep", 32'(occupied), cnt_exp(2));
    n = 0;
    while (clr_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("occ_sweep_finished", 32'(clr_busy), 0);
    check("occ_after_sweep", 32'(occupied), 0);

    // Asynchronous reset clears rd_data immediately and restarts the sweep.
    do_write(9, 9, 1'b1);
    rd_x = 6'd9;
    rd_y = 5'd9;
    @(negedge clk);
    check("pre_rst_rd", 32'(rd_data), 1);
    rst = 1'b1;
    #1;
    check("async_rst_rd", 32'(rd_data), 0);
    check("async_rst_busy", 32'(clr_busy), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (clr_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_sweep_len", 32'(n), 18);
    rd_x = 6'd9;
    rd_y = 5'd9;
    @(negedge clk);
    check("rst_mid_sweep_cleared", 32'(rd_data), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
